pipeline_controller: RTL and testbench
======================================

# pipeline_controller

Central hazard and sequencing controller for the five-stage core. Drives the per-boundary `control` (stall/flush) structs, the execute-stage forwarding selects and data, and the fetch redirect. Sequences three events: load-use bubbles, branch/jump redirects that must be held until instruction memory accepts them, and interrupt entry (drain, flush, vector).

## Interface
Parameters:
- `RESET_VECTOR`, 32'h0000_0000: redirect target issued once after reset release.

Ports:
- `clock`  in  1  core clock
- `reset`  in  1  asynchronous, active-low reset
- `decodeSource1`, `decodeSource2`  in  5  rs1/rs2 of the instruction in decode
- `decodeUses1`, `decodeUses2`  in  1  decode instruction reads rs1/rs2
- `decodeValid`  in  1  decode slot valid
- `decodeProgramCounter`  in  32  PC in decode (trap return address)
- `executeSource1`, `executeSource2`  in  5  rs1/rs2 of the instruction in execute
- `executeDestination`  in  5  rd in execute
- `executeValid`, `executeLoad`  in  1  execute slot valid; execute is a load
- `memoryDestination`  in  5  rd in memory
- `memoryValid`, `memoryWrites`  in  1  memory slot valid; it writes rd
- `memoryForwardData`  in  32  memory-stage result (ALU result or PC+4)
- `writebackDestination`  in  5  rd in writeback
- `writebackValid`, `writebackWrites`  in  1  writeback slot valid; it writes rd
- `writebackData`  in  32  final writeback value
- `branchValid`  in  1  taken branch/jump from execute
- `branchData`  in  32  redirect target from execute
- `imemReady`  in  1  fetch accepts a redirect this cycle
- `dmemBusy`  in  1  data memory cannot complete this cycle
- `interrupt`  in  1  level-sensitive external interrupt
- `trapVector`  in  32  interrupt handler address
- `fetchDecodeControl`, `decodeExecuteControl`, `executeMemoryControl`, `memoryWritebackControl`  out  `control`  stall/flush per boundary
- `forwardEnable1`, `forwardEnable2`  out  1  execute operand override
- `forwardData1`, `forwardData2`  out  32  override values
- `redirectValid`  out  1  fetch PC override
- `redirectAddress`  out  32  new fetch PC
- `trapTaken`  out  1  one-cycle pulse on interrupt entry
- `trapReturnAddress`  out  32  PC saved at entry (registered)

## Operation
- States: BOOT, RUN, HOLD, DRAIN, TRAP.
- BOOT (after reset release): redirectValid=1, redirectAddress=RESET_VECTOR. On imemReady go to RUN.
- Forwarding, combinational in every state:
  - Source k is forwarded from memory if memoryValid & memoryWrites & rd≠0 & rd==executeSourcek.
  - Otherwise it is forwarded from writeback under the same rule.
  - Memory has priority. Source x0 is never forwarded.
- Load-use, RUN only: executeValid & executeLoad & executeDestination≠0 & decodeValid & (decodeUsesk & decodeSourcek==executeDestination).
  - Response: stall fetchDecode, flush decodeExecute. Exactly one bubble per hazard.
- dmemBusy: stall executeMemory and every earlier boundary; flush memoryWriteback. Flushes override stalls on the same boundary.
- Redirect, in RUN on branchValid:
  - Flush fetchDecode and decodeExecute.
  - Drive redirectValid=1 with redirectAddress=branchData.
  - If !imemReady, latch the target and go to HOLD.
- HOLD: re-drive the latched target and flush fetchDecode every cycle. Return to RUN on imemReady.
- Interrupt: a sticky pending bit is set on interrupt. It is acted on only in RUN with no branchValid; a same-cycle branch wins and the interrupt stays pending.
- DRAIN:
  - Latch decodeProgramCounter into trapReturnAddress.
  - Stall fetchDecode and flush decodeExecute.
  - Wait until !executeValid, !memoryValid and !dmemBusy, then go to TRAP.
- TRAP, one cycle:
  - Flush all four boundaries.
  - redirectValid=1 with trapVector.
  - trapTaken=1 and clear pending.
  - Go to RUN if imemReady; otherwise go to HOLD with trapVector latched.

## Timing
- Reset asserted: all stall=0, all flush=1; redirectValid=0, trapTaken=0, forwardEnable=0, trapReturnAddress=0; state=BOOT, pending=0.
- Reset deassertion mid-redirect discards the latched target and restarts from BOOT.
- Forwarding, load-use and first-cycle redirect outputs are zero-latency (combinational on inputs).
- HOLD/DRAIN/TRAP outputs are Moore (state registers only), except the imemReady exit.
- Interrupt entry latency: DRAIN cycles plus 1 cycle of TRAP, counted from the first RUN cycle with pending set.
- branchValid during HOLD or DRAIN is ignored; execute suppresses re-assertion itself.

## Structure
- Package `pack`:
  - Add `controllerState_` enum {CTRL_BOOT, CTRL_RUN, CTRL_HOLD, CTRL_DRAIN, CTRL_TRAP}.
  - Reuse the existing `control` struct (stall, flush).
- Sub-module `forward_unit`: purely combinational source match and data mux, instantiated once per operand.

## Test plan
- Reset low, then release with imemReady=1 → redirectValid=1 and address 0x0 for one cycle, then RUN.
- Memory rd=5 (result 0xAAAA) and writeback rd=5 (0xBBBB), executeSource1=5 → forwardEnable1=1, forwardData1=0xAAAA. Same with rd=0 → forwardEnable1=0.
- Load to x7 in execute, decode uses rs2=7 → exactly one cycle with fetchDecode.stall=1 and decodeExecute.flush=1.
- branchValid with branchData=0x100 and imemReady low for 3 cycles → redirect to 0x100 held 4 cycles; fetchDecode.flush held throughout.
- interrupt and branchValid in the same cycle → branch redirect first; trapTaken only after drain; trapReturnAddress equals decode PC at DRAIN entry.
- Reset asserted during DRAIN → all flushes=1 immediately (asynchronous); no trapTaken after release.

Source files
------------

// File: rtl/pack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : pack                                                         |
// | Purpose   : Shared types for the core pipeline: the per-boundary         |
// |             stall/flush control struct, the hazard controller state      |
// |             encoding and the boundary index constants.                   |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package pack;

   // Per pipeline-boundary control. A flushed boundary loads a bubble; a
   // stalled boundary holds its current contents.
   typedef struct packed {
      logic stall;
      logic flush;
   } control;

   typedef enum logic [2:0] {
      CTRL_BOOT  = 3'd0,
      CTRL_RUN   = 3'd1,
      CTRL_HOLD  = 3'd2,
      CTRL_DRAIN = 3'd3,
      CTRL_TRAP  = 3'd4
   } controllerState_;

   // Bit positions of each boundary inside the controller's 4-bit
   // stall/flush request vectors.
   localparam logic [1:0] c_FD = 2'd3;   // fetch -> decode
   localparam logic [1:0] c_DE = 2'd2;   // decode -> execute
   localparam logic [1:0] c_EM = 2'd1;   // execute -> memory
   localparam logic [1:0] c_MW = 2'd0;   // memory -> writeback

   localparam logic [4:0] c_REG_ZERO = 5'd0;

   // A boundary that is both stalled and flushed must take the bubble, so
   // the flush suppresses the stall.
   function automatic control resolveControl(input logic stall, input logic flush);
      control result;
      result.stall = stall & ~flush;
      result.flush = flush;
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : forward_unit                                                 |
// | Purpose   : Combinational operand bypass for one execute-stage source.   |
// |             Picks the youngest in-flight producer of the register.       |
// | Ports     : source                    register read in execute           |
// |             memoryDestination/Valid/Writes/Data     memory producer      |
// |             writebackDestination/Valid/Writes/Data  writeback producer   |
// |             enable                    override the register file value   |
// |             data                      value to use (0 when not enabled)  |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module forward_unit
   import pack::*;
(
   input  logic [4:0]  source,
   input  logic [4:0]  memoryDestination,
   input  logic        memoryValid,
   input  logic        memoryWrites,
   input  logic [31:0] memoryData,
   input  logic [4:0]  writebackDestination,
   input  logic        writebackValid,
   input  logic        writebackWrites,
   input  logic [31:0] writebackData,
   output logic        enable,
   output logic [31:0] data
);

   logic w_memoryHit;
   logic w_writebackHit;

   // rd must be non-zero, so an x0 source can never match.
   assign w_memoryHit = memoryValid & memoryWrites &
                        (memoryDestination != c_REG_ZERO) &
                        (memoryDestination == source);

   assign w_writebackHit = writebackValid & writebackWrites &
                           (writebackDestination != c_REG_ZERO) &
                           (writebackDestination == source);

   // Memory holds the younger result and therefore wins.
   always_comb begin
      enable = 1'b0;
      data   = 32'h0000_0000;
      if (w_memoryHit) begin
         enable = 1'b1;
         data   = memoryData;
      end else if (w_writebackHit) begin
         enable = 1'b1;
         data   = writebackData;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipeline_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : pipeline_controller                                          |
// | Purpose   : Hazard and sequencing controller for the five-stage core.    |
// |             Generates per-boundary stall/flush, execute operand bypass,  |
// |             fetch redirects (boot, branch, trap) and interrupt entry.    |
// | Ports     : clock, reset (async active-low)                              |
// |             decode*     : decode slot sources, valid, PC                 |
// |             execute*    : execute slot sources, rd, valid, load          |
// |             memory*     : memory slot rd, valid, writes, result          |
// |             writeback*  : writeback slot rd, valid, writes, value        |
// |             branch*     : taken branch/jump and target from execute      |
// |             imemReady   : fetch accepts a redirect this cycle            |
// |             dmemBusy    : data memory stalls the back end                |
// |             interrupt / trapVector : external interrupt and handler PC   |
// |             *Control    : stall/flush per boundary                       |
// |             forward*    : execute operand overrides                      |
// |             redirect*   : fetch PC override                              |
// |             trapTaken / trapReturnAddress : interrupt entry pulse and PC |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module pipeline_controller
   import pack::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  decodeSource1,
   input  logic [4:0]  decodeSource2,
   input  logic        decodeUses1,
   input  logic        decodeUses2,
   input  logic        decodeValid,
   input  logic [31:0] decodeProgramCounter,
   input  logic [4:0]  executeSource1,
   input  logic [4:0]  executeSource2,
   input  logic [4:0]  executeDestination,
   input  logic        executeValid,
   input  logic        executeLoad,
   input  logic [4:0]  memoryDestination,
   input  logic        memoryValid,
   input  logic        memoryWrites,
   input  logic [31:0] memoryForwardData,
   input  logic [4:0]  writebackDestination,
   input  logic        writebackValid,
   input  logic        writebackWrites,
   input  logic [31:0] writebackData,
   input  logic        branchValid,
   input  logic [31:0] branchData,
   input  logic        imemReady,
   input  logic        dmemBusy,
   input  logic        interrupt,
   input  logic [31:0] trapVector,
   output control      fetchDecodeControl,
   output control      decodeExecuteControl,
   output control      executeMemoryControl,
   output control      memoryWritebackControl,
   output logic        forwardEnable1,
   output logic        forwardEnable2,
   output logic [31:0] forwardData1,
   output logic [31:0] forwardData2,
   output logic        redirectValid,
   output logic [31:0] redirectAddress,
   output logic        trapTaken,
   output logic [31:0] trapReturnAddress
);

   controllerState_ r_state;
   controllerState_ w_nextState;
   logic            r_pending;
   logic [31:0]     r_heldTarget;
   logic [31:0]     r_trapReturn;

   logic            w_latchTarget;
   logic [31:0]     w_latchValue;
   logic [3:0]      w_stall;
   logic [3:0]      w_flush;
   logic            w_redirect;
   logic [31:0]     w_redirectAddr;
   logic            w_trapPulse;
   logic            w_loadUse;
   logic            w_forwardEnable1;
   logic            w_forwardEnable2;

   // ------------------------------------------------------------------
   // Operand bypass, one unit per execute source
   // ------------------------------------------------------------------
   forward_unit u_forward1 (
      .source               (executeSource1),
      .memoryDestination    (memoryDestination),
      .memoryValid          (memoryValid),
      .memoryWrites         (memoryWrites),
      .memoryData           (memoryForwardData),
      .writebackDestination (writebackDestination),
      .writebackValid       (writebackValid),
      .writebackWrites      (writebackWrites),
      .writebackData        (writebackData),
      .enable               (w_forwardEnable1),
      .data                 (forwardData1)
   );

   forward_unit u_forward2 (
      .source               (executeSource2),
      .memoryDestination    (memoryDestination),
      .memoryValid          (memoryValid),
      .memoryWrites         (memoryWrites),
      .memoryData           (memoryForwardData),
      .writebackDestination (writebackDestination),
      .writebackValid       (writebackValid),
      .writebackWrites      (writebackWrites),
      .writebackData        (writebackData),
      .enable               (w_forwardEnable2),
      .data                 (forwardData2)
   );

   // Bypass is meaningless while the core is held in reset.
   assign forwardEnable1 = reset & w_forwardEnable1;
   assign forwardEnable2 = reset & w_forwardEnable2;

   // A load result is only available from memory onwards, so a dependent
   // instruction in decode has to wait exactly one cycle.
   assign w_loadUse = executeValid & executeLoad &
                      (executeDestination != c_REG_ZERO) & decodeValid &
                      ((decodeUses1 & (decodeSource1 == executeDestination)) |
                       (decodeUses2 & (decodeSource2 == executeDestination)));

   // ------------------------------------------------------------------
   // Next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_nextState    = r_state;
      w_latchTarget  = 1'b0;
      w_latchValue   = r_heldTarget;
      w_stall        = 4'b0000;
      w_flush        = 4'b0000;
      w_redirect     = 1'b0;
      w_redirectAddr = r_heldTarget;
      w_trapPulse    = 1'b0;

      case (r_state)
         CTRL_BOOT: begin
            w_redirect     = 1'b1;
            w_redirectAddr = RESET_VECTOR;
            w_flush[c_FD]  = 1'b1;
            if (imemReady) begin
               w_nextState = CTRL_RUN;
            end
         end

         CTRL_RUN: begin
            if (w_loadUse) begin
               w_stall[c_FD] = 1'b1;
               w_flush[c_DE] = 1'b1;
            end
            // A branch in the same cycle takes precedence; the interrupt
            // stays pending and is taken once the redirect is accepted.
            if (branchValid) begin
               w_flush[c_FD]  = 1'b1;
               w_flush[c_DE]  = 1'b1;
               w_redirect     = 1'b1;
               w_redirectAddr = branchData;
               if (!imemReady) begin
                  w_nextState   = CTRL_HOLD;
                  w_latchTarget = 1'b1;
                  w_latchValue  = branchData;
               end
            end else if (r_pending) begin
               w_nextState = CTRL_DRAIN;
            end
         end

         CTRL_HOLD: begin
            w_redirect    = 1'b1;
            w_flush[c_FD] = 1'b1;
            if (imemReady) begin
               w_nextState = CTRL_RUN;
            end
         end

         CTRL_DRAIN: begin
            // Freeze the instruction in decode (its PC is the return
            // address) and let older instructions retire.
            w_stall[c_FD] = 1'b1;
            w_flush[c_DE] = 1'b1;
            if (!executeValid && !memoryValid && !dmemBusy) begin
               w_nextState = CTRL_TRAP;
            end
         end

         CTRL_TRAP: begin
            w_flush        = 4'b1111;
            w_redirect     = 1'b1;
            w_redirectAddr = trapVector;
            w_trapPulse    = 1'b1;
            if (imemReady) begin
               w_nextState = CTRL_RUN;
            end else begin
               w_nextState   = CTRL_HOLD;
               w_latchTarget = 1'b1;
               w_latchValue  = trapVector;
            end
         end

         default: begin
            w_nextState = CTRL_BOOT;
         end
      endcase

      // Data memory back-pressure freezes everything up to memory and
      // drops a bubble into writeback.
      if (dmemBusy) begin
         w_stall[c_FD] = 1'b1;
         w_stall[c_DE] = 1'b1;
         w_stall[c_EM] = 1'b1;
         w_flush[c_MW] = 1'b1;
      end

      // Outputs follow reset asynchronously rather than waiting for an edge.
      if (!reset) begin
         w_stall     = 4'b0000;
         w_flush     = 4'b1111;
         w_redirect  = 1'b0;
         w_trapPulse = 1'b0;
      end
   end

   assign fetchDecodeControl     = resolveControl(w_stall[c_FD], w_flush[c_FD]);
   assign decodeExecuteControl   = resolveControl(w_stall[c_DE], w_flush[c_DE]);
   assign executeMemoryControl   = resolveControl(w_stall[c_EM], w_flush[c_EM]);
   assign memoryWritebackControl = resolveControl(w_stall[c_MW], w_flush[c_MW]);
   assign redirectValid          = w_redirect;
   assign redirectAddress        = w_redirectAddr;
   assign trapTaken              = w_trapPulse;
   assign trapReturnAddress      = r_trapReturn;

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= CTRL_BOOT;
         r_pending    <= 1'b0;
         r_heldTarget <= 32'h0000_0000;
         r_trapReturn <= 32'h0000_0000;
      end else begin
         r_state <= w_nextState;

         // Entry consumes the request; a still-asserted level re-arms it
         // from the following cycle.
         if (r_state == CTRL_TRAP) begin
            r_pending <= 1'b0;
         end else begin
            r_pending <= r_pending | interrupt;
         end

         if (w_latchTarget) begin
            r_heldTarget <= w_latchValue;
         end

         // Decode is stalled throughout DRAIN, so its PC is stable here.
         if (r_state == CTRL_DRAIN) begin
            r_trapReturn <= decodeProgramCounter;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_pipeline_controller                                       |
// | Purpose   : Self-checking bench for pipeline_controller. Directed        |
// |             scenario tasks plus randomized RUN-state traffic compared    |
// |             against a behavioural reference model.                       |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pipeline_controller;
   import pack::*;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  decodeSource1, decodeSource2;
   logic        decodeUses1, decodeUses2, decodeValid;
   logic [31:0] decodeProgramCounter;
   logic [4:0]  executeSource1, executeSource2, executeDestination;
   logic        executeValid, executeLoad;
   logic [4:0]  memoryDestination;
   logic        memoryValid, memoryWrites;
   logic [31:0] memoryForwardData;
   logic [4:0]  writebackDestination;
   logic        writebackValid, writebackWrites;
   logic [31:0] writebackData;
   logic        branchValid;
   logic [31:0] branchData;
   logic        imemReady, dmemBusy, interrupt;
   logic [31:0] trapVector;
   control      fetchDecodeControl, decodeExecuteControl;
   control      executeMemoryControl, memoryWritebackControl;
   logic        forwardEnable1, forwardEnable2;
   logic [31:0] forwardData1, forwardData2;
   logic        redirectValid;
   logic [31:0] redirectAddress;
   logic        trapTaken;
   logic [31:0] trapReturnAddress;

   int checks = 0;
   int errors = 0;

   // {FD.stall, FD.flush, DE.stall, DE.flush, EM.stall, EM.flush, MW.stall, MW.flush}
   logic [7:0] ctlVec;
   assign ctlVec = {fetchDecodeControl, decodeExecuteControl,
                    executeMemoryControl, memoryWritebackControl};

   localparam logic [7:0] CTL_NONE    = 8'b00_00_00_00;
   localparam logic [7:0] CTL_ALLFL   = 8'b01_01_01_01;
   localparam logic [7:0] CTL_BUBBLE  = 8'b10_01_00_00;
   localparam logic [7:0] CTL_FDFLUSH = 8'b01_00_00_00;
   localparam logic [7:0] CTL_BRANCH  = 8'b01_01_00_00;

   pipeline_controller #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clock(clock), .reset(reset),
      .decodeSource1(decodeSource1), .decodeSource2(decodeSource2),
      .decodeUses1(decodeUses1), .decodeUses2(decodeUses2),
      .decodeValid(decodeValid), .decodeProgramCounter(decodeProgramCounter),
      .executeSource1(executeSource1), .executeSource2(executeSource2),
      .executeDestination(executeDestination), .executeValid(executeValid),
      .executeLoad(executeLoad),
      .memoryDestination(memoryDestination), .memoryValid(memoryValid),
      .memoryWrites(memoryWrites), .memoryForwardData(memoryForwardData),
      .writebackDestination(writebackDestination), .writebackValid(writebackValid),
      .writebackWrites(writebackWrites), .writebackData(writebackData),
      .branchValid(branchValid), .branchData(branchData),
      .imemReady(imemReady), .dmemBusy(dmemBusy), .interrupt(interrupt),
      .trapVector(trapVector),
      .fetchDecodeControl(fetchDecodeControl), .decodeExecuteControl(decodeExecuteControl),
      .executeMemoryControl(executeMemoryControl), .memoryWritebackControl(memoryWritebackControl),
      .forwardEnable1(forwardEnable1), .forwardEnable2(forwardEnable2),
      .forwardData1(forwardData1), .forwardData2(forwardData2),
      .redirectValid(redirectValid), .redirectAddress(redirectAddress),
      .trapTaken(trapTaken), .trapReturnAddress(trapReturnAddress)
   );

   always #5 clock = ~clock;

   task automatic clear_inputs();
      decodeSource1 = 0; decodeSource2 = 0; decodeUses1 = 0; decodeUses2 = 0;
      decodeValid = 0; decodeProgramCounter = 0;
      executeSource1 = 0; executeSource2 = 0; executeDestination = 0;
      executeValid = 0; executeLoad = 0;
      memoryDestination = 0; memoryValid = 0; memoryWrites = 0; memoryForwardData = 0;
      writebackDestination = 0; writebackValid = 0; writebackWrites = 0; writebackData = 0;
      branchValid = 0; branchData = 0; imemReady = 1; dmemBusy = 0; interrupt = 0;
      trapVector = 32'h0000_0800;
   endtask

   // Reference bypass: scan producers youngest first, the first one that
   // really writes the register supplies the value. Result is {enable, data}.
   function automatic logic [32:0] fwd_model(input logic [4:0] src);
      logic [4:0]  rd  [2];
      logic        wr  [2];
      logic [31:0] val [2];
      rd[0] = memoryDestination;    wr[0] = memoryValid & memoryWrites;       val[0] = memoryForwardData;
      rd[1] = writebackDestination; wr[1] = writebackValid & writebackWrites; val[1] = writebackData;
      for (int p = 0; p < 2; p++)
         if (wr[p] && rd[p] != 0 && rd[p] == src) return {1'b1, val[p]};
      return 33'd0;
   endfunction

   // Reference RUN-state boundary control built from the hazard rules.
   function automatic logic [7:0] ctl_model();
      logic [3:0] st, fl;   // index 3 = fetch/decode ... 0 = memory/writeback
      logic hazard;
      st = 0; fl = 0;
      hazard = executeValid && executeLoad && executeDestination != 0 && decodeValid &&
               ((decodeUses1 && decodeSource1 == executeDestination) ||
                (decodeUses2 && decodeSource2 == executeDestination));
      if (hazard)      begin st[3] = 1; fl[2] = 1; end
      if (branchValid) begin fl[3] = 1; fl[2] = 1; end
      if (dmemBusy)    begin st[3:1] = 3'b111; fl[0] = 1; end
      st = st & ~fl;
      return {st[3], fl[3], st[2], fl[2], st[1], fl[1], st[0], fl[0]};
   endfunction

   task automatic test_reset();
      clear_inputs();
      memoryValid = 1; memoryWrites = 1; memoryDestination = 5;
      memoryForwardData = 32'hAAAA; executeSource1 = 5;
      branchValid = 1; branchData = 32'h1234;
      reset = 0;
      repeat (2) @(negedge clock);
      #1;
      checks++; if (ctlVec !== CTL_ALLFL) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctlVec, CTL_ALLFL); end
      checks++; if (redirectValid !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b want 0", redirectValid); end
      checks++; if (trapTaken !== 1'b0) begin errors++; $display("FAIL reset_trap: got %b want 0", trapTaken); end
      checks++; if (forwardEnable1 !== 1'b0) begin errors++; $display("FAIL reset_fwd: got %b want 0", forwardEnable1); end
      checks++; if (trapReturnAddress !== 32'h0) begin errors++; $display("FAIL reset_tra: got %h want 0", trapReturnAddress); end
      @(negedge clock);
      clear_inputs();
      reset = 1;
      #1;
      checks++; if (redirectValid !== 1'b1 || redirectAddress !== 32'h0) begin errors++;
         $display("FAIL boot_redirect: got %b/%h want 1/00000000", redirectValid, redirectAddress); end
      @(negedge clock); #1;
      checks++; if (redirectValid !== 1'b0 || ctlVec !== CTL_NONE) begin errors++;
         $display("FAIL boot_exit: got redirect %b ctl %b want 0 / %b", redirectValid, ctlVec, CTL_NONE); end
   endtask

   task automatic test_forward_directed();
      @(negedge clock); clear_inputs();
      memoryValid = 1; memoryWrites = 1; memoryDestination = 5; memoryForwardData = 32'hAAAA;
      writebackValid = 1; writebackWrites = 1; writebackDestination = 5; writebackData = 32'hBBBB;
      executeSource1 = 5; executeSource2 = 5;
      #1;
      checks++; if (forwardEnable1 !== 1'b1 || forwardData1 !== 32'hAAAA) begin errors++;
         $display("FAIL fwd_mem_priority: got %b/%h want 1/0000aaaa", forwardEnable1, forwardData1); end
      @(negedge clock);
      memoryDestination = 0; writebackDestination = 0; executeSource1 = 0; executeSource2 = 0;
      #1;
      checks++; if (forwardEnable1 !== 1'b0 || forwardEnable2 !== 1'b0) begin errors++;
         $display("FAIL fwd_x0: got %b%b want 00", forwardEnable1, forwardEnable2); end
      @(negedge clock);
      memoryDestination = 6; writebackDestination = 5; executeSource2 = 5;
      #1;
      checks++; if (forwardEnable2 !== 1'b1 || forwardData2 !== 32'hBBBB) begin errors++;
         $display("FAIL fwd_wb: got %b/%h want 1/0000bbbb", forwardEnable2, forwardData2); end
      @(negedge clock);
      memoryDestination = 5; memoryWrites = 0;
      #1;
      checks++; if (forwardEnable2 !== 1'b1 || forwardData2 !== 32'hBBBB) begin errors++;
         $display("FAIL fwd_mem_nowrite: got %b/%h want 1/0000bbbb", forwardEnable2, forwardData2); end
   endtask

   task automatic test_load_use();
      int bubbles = 0;
      @(negedge clock); clear_inputs();
      executeValid = 1; executeLoad = 1; executeDestination = 7; executeSource1 = 3;
      decodeValid = 1; decodeUses1 = 1; decodeSource1 = 2; decodeUses2 = 1; decodeSource2 = 7;
      #1;
      if (fetchDecodeControl.stall && decodeExecuteControl.flush) bubbles++;
      checks++; if (ctlVec !== CTL_BUBBLE) begin errors++; $display("FAIL loaduse_bubble: got %b want %b", ctlVec, CTL_BUBBLE); end
      // load advances to memory, bubble in execute, dependent still in decode
      @(negedge clock);
      executeValid = 0; executeLoad = 0; executeDestination = 0;
      memoryValid = 1; memoryWrites = 1; memoryDestination = 7; memoryForwardData = 32'hCAFE;
      #1;
      if (fetchDecodeControl.stall && decodeExecuteControl.flush) bubbles++;
      checks++; if (ctlVec !== CTL_NONE) begin errors++; $display("FAIL loaduse_release: got %b want %b", ctlVec, CTL_NONE); end
      // dependent reaches execute, load now in writeback
      @(negedge clock);
      executeValid = 1; executeSource1 = 2; executeSource2 = 7; executeDestination = 9;
      memoryValid = 0; memoryWrites = 0; memoryDestination = 0;
      writebackValid = 1; writebackWrites = 1; writebackDestination = 7; writebackData = 32'hCAFE;
      #1;
      if (fetchDecodeControl.stall && decodeExecuteControl.flush) bubbles++;
      checks++; if (forwardEnable2 !== 1'b1 || forwardData2 !== 32'hCAFE || ctlVec !== CTL_NONE) begin errors++;
         $display("FAIL loaduse_forward: got %b/%h ctl %b want 1/0000cafe ctl %b", forwardEnable2, forwardData2, ctlVec, CTL_NONE); end
      checks++; if (bubbles != 1) begin errors++; $display("FAIL loaduse_count: got %0d want 1", bubbles); end
   endtask

   task automatic test_branch_hold();
      int held = 0;
      @(negedge clock); clear_inputs();
      branchValid = 1; branchData = 32'h100; imemReady = 0;
      #1;
      if (redirectValid && redirectAddress == 32'h100) held++;
      checks++; if (redirectValid !== 1'b1 || redirectAddress !== 32'h100 || ctlVec !== CTL_BRANCH) begin errors++;
         $display("FAIL branch_first: got %b/%h ctl %b want 1/00000100 ctl %b", redirectValid, redirectAddress, ctlVec, CTL_BRANCH); end
      for (int c = 1; c <= 3; c++) begin
         @(negedge clock);
         branchValid = 1; branchData = 32'h200;   // must be ignored while holding
         imemReady = (c == 3);
         #1;
         if (redirectValid && redirectAddress == 32'h100) held++;
         checks++; if (redirectValid !== 1'b1 || redirectAddress !== 32'h100 || ctlVec !== CTL_FDFLUSH) begin errors++;
            $display("FAIL branch_hold%0d: got %b/%h ctl %b want 1/00000100 ctl %b", c, redirectValid, redirectAddress, ctlVec, CTL_FDFLUSH); end
      end
      @(negedge clock);
      branchValid = 0; imemReady = 1;
      #1;
      if (redirectValid && redirectAddress == 32'h100) held++;
      checks++; if (redirectValid !== 1'b0 || ctlVec !== CTL_NONE) begin errors++;
         $display("FAIL branch_release: got %b ctl %b want 0 ctl %b", redirectValid, ctlVec, CTL_NONE); end
      checks++; if (held != 4) begin errors++; $display("FAIL branch_hold_len: got %0d want 4", held); end
   endtask

   task automatic test_random_run();
      logic [32:0] e1, e2;
      logic [7:0]  ec;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         decodeSource1 = 5'($urandom_range(0, 3)); decodeSource2 = 5'($urandom_range(0, 3));
         decodeUses1 = 1'($urandom_range(0, 1)); decodeUses2 = 1'($urandom_range(0, 1));
         decodeValid = 1'($urandom_range(0, 1));
         executeSource1 = 5'($urandom_range(0, 3)); executeSource2 = 5'($urandom_range(0, 3));
         executeDestination = 5'($urandom_range(0, 3));
         executeValid = 1'($urandom_range(0, 1)); executeLoad = 1'($urandom_range(0, 1));
         memoryDestination = 5'($urandom_range(0, 3));
         memoryValid = 1'($urandom_range(0, 1)); memoryWrites = 1'($urandom_range(0, 1));
         memoryForwardData = $urandom;
         writebackDestination = 5'($urandom_range(0, 3));
         writebackValid = 1'($urandom_range(0, 1)); writebackWrites = 1'($urandom_range(0, 1));
         writebackData = $urandom;
         branchValid = ($urandom_range(0, 3) == 0); branchData = $urandom;
         dmemBusy = ($urandom_range(0, 3) == 0);
         imemReady = 1; interrupt = 0;
         #1;
         e1 = fwd_model(executeSource1);
         e2 = fwd_model(executeSource2);
         ec = ctl_model();
         checks++; if (forwardEnable1 !== e1[32] || (e1[32] && forwardData1 !== e1[31:0])) begin errors++;
            $display("FAIL rand_fwd1 #%0d: got %b/%h want %b/%h", i, forwardEnable1, forwardData1, e1[32], e1[31:0]); end
         checks++; if (forwardEnable2 !== e2[32] || (e2[32] && forwardData2 !== e2[31:0])) begin errors++;
            $display("FAIL rand_fwd2 #%0d: got %b/%h want %b/%h", i, forwardEnable2, forwardData2, e2[32], e2[31:0]); end
         checks++; if (ctlVec !== ec) begin errors++;
            $display("FAIL rand_ctl #%0d: got %b want %b", i, ctlVec, ec); end
         checks++; if (redirectValid !== branchValid || (branchValid && redirectAddress !== branchData)) begin errors++;
            $display("FAIL rand_redirect #%0d: got %b/%h want %b/%h", i, redirectValid, redirectAddress, branchValid, branchData); end
      end
   endtask

   task automatic test_interrupt();
      @(negedge clock); clear_inputs();
      interrupt = 1; branchValid = 1; branchData = 32'h300; imemReady = 0;
      #1;
      checks++; if (redirectValid !== 1'b1 || redirectAddress !== 32'h300 || trapTaken !== 1'b0) begin errors++;
         $display("FAIL irq_branch_first: got %b/%h trap %b want 1/00000300 trap 0", redirectValid, redirectAddress, trapTaken); end
      @(negedge clock);
      interrupt = 0; branchValid = 0; imemReady = 1;
      #1;
      checks++; if (redirectValid !== 1'b1 || redirectAddress !== 32'h300 || trapTaken !== 1'b0) begin errors++;
         $display("FAIL irq_hold: got %b/%h trap %b want 1/00000300 trap 0", redirectValid, redirectAddress, trapTaken); end
      @(negedge clock);                           // first RUN cycle with pending set
      decodeValid = 1; decodeProgramCounter = 32'h4FC;
      #1;
      checks++; if (redirectValid !== 1'b0 || trapTaken !== 1'b0 || ctlVec !== CTL_NONE) begin errors++;
         $display("FAIL irq_run: got %b trap %b ctl %b want 0 trap 0 ctl %b", redirectValid, trapTaken, ctlVec, CTL_NONE); end
      @(negedge clock);                           // DRAIN 1: execute still busy
      decodeProgramCounter = 32'h500; executeValid = 1;
      #1;
      checks++; if (ctlVec !== CTL_BUBBLE || trapTaken !== 1'b0 || redirectValid !== 1'b0) begin errors++;
         $display("FAIL irq_drain1: got ctl %b trap %b redirect %b want ctl %b 0 0", ctlVec, trapTaken, redirectValid, CTL_BUBBLE); end
      @(negedge clock);                           // DRAIN 2: memory busy
      executeValid = 0; memoryValid = 1;
      #1;
      checks++; if (ctlVec !== CTL_BUBBLE || trapTaken !== 1'b0 || trapReturnAddress !== 32'h500) begin errors++;
         $display("FAIL irq_drain2: got ctl %b trap %b tra %h want ctl %b 0 00000500", ctlVec, trapTaken, trapReturnAddress, CTL_BUBBLE); end
      @(negedge clock);                           // DRAIN 3: data memory busy
      memoryValid = 0; dmemBusy = 1;
      #1;
      checks++; if (ctlVec !== 8'b10_01_10_01 || trapTaken !== 1'b0) begin errors++;
         $display("FAIL irq_drain3: got ctl %b trap %b want ctl 10011001 0", ctlVec, trapTaken); end
      @(negedge clock);                           // DRAIN 4: empty
      dmemBusy = 0;
      #1;
      checks++; if (ctlVec !== CTL_BUBBLE || trapTaken !== 1'b0) begin errors++;
         $display("FAIL irq_drain4: got ctl %b trap %b want ctl %b 0", ctlVec, trapTaken, CTL_BUBBLE); end
      @(negedge clock);                           // TRAP
      trapVector = 32'h800; imemReady = 1;
      #1;
      checks++; if (trapTaken !== 1'b1 || redirectValid !== 1'b1 || redirectAddress !== 32'h800 || ctlVec !== CTL_ALLFL) begin errors++;
         $display("FAIL irq_trap: got trap %b %b/%h ctl %b want 1 1/00000800 ctl %b", trapTaken, redirectValid, redirectAddress, ctlVec, CTL_ALLFL); end
      checks++; if (trapReturnAddress !== 32'h500) begin errors++;
         $display("FAIL irq_return_addr: got %h want 00000500", trapReturnAddress); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clock); #1;
         checks++; if (trapTaken !== 1'b0 || redirectValid !== 1'b0 || ctlVec !== CTL_NONE) begin errors++;
            $display("FAIL irq_after%0d: got trap %b redirect %b ctl %b want 0 0 %b", c, trapTaken, redirectValid, ctlVec, CTL_NONE); end
      end
   endtask

   task automatic test_trap_hold();
      @(negedge clock); clear_inputs();
      interrupt = 1;
      @(negedge clock);
      interrupt = 0;
      #1;
      checks++; if (ctlVec !== CTL_NONE || trapTaken !== 1'b0) begin errors++;
         $display("FAIL traphold_run: got ctl %b trap %b want %b 0", ctlVec, trapTaken, CTL_NONE); end
      @(negedge clock);
      decodeProgramCounter = 32'h640;
      #1;
      checks++; if (ctlVec !== CTL_BUBBLE) begin errors++; $display("FAIL traphold_drain: got %b want %b", ctlVec, CTL_BUBBLE); end
      @(negedge clock);
      imemReady = 0; trapVector = 32'h800;
      #1;
      checks++; if (trapTaken !== 1'b1 || redirectAddress !== 32'h800 || trapReturnAddress !== 32'h640) begin errors++;
         $display("FAIL traphold_trap: got trap %b addr %h tra %h want 1 00000800 00000640", trapTaken, redirectAddress, trapReturnAddress); end
      @(negedge clock);
      trapVector = 32'h900;
      #1;
      checks++; if (trapTaken !== 1'b0 || redirectValid !== 1'b1 || redirectAddress !== 32'h800 || ctlVec !== CTL_FDFLUSH) begin errors++;
         $display("FAIL traphold_hold: got trap %b %b/%h ctl %b want 0 1/00000800 %b", trapTaken, redirectValid, redirectAddress, ctlVec, CTL_FDFLUSH); end
      @(negedge clock);
      imemReady = 1;
      #1;
      checks++; if (redirectValid !== 1'b1 || redirectAddress !== 32'h800) begin errors++;
         $display("FAIL traphold_exit: got %b/%h want 1/00000800", redirectValid, redirectAddress); end
      @(negedge clock); #1;
      checks++; if (redirectValid !== 1'b0) begin errors++; $display("FAIL traphold_run2: got %b want 0", redirectValid); end
   endtask

   task automatic test_reset_in_drain();
      int traps = 0;
      @(negedge clock); clear_inputs();
      interrupt = 1;
      @(negedge clock);
      interrupt = 0;
      @(negedge clock);
      executeValid = 1;
      #1;
      checks++; if (ctlVec !== CTL_BUBBLE) begin errors++; $display("FAIL rstdrain_drain: got %b want %b", ctlVec, CTL_BUBBLE); end
      #1;
      reset = 0;
      #1;
      checks++; if (ctlVec !== CTL_ALLFL || redirectValid !== 1'b0 || trapTaken !== 1'b0) begin errors++;
         $display("FAIL rstdrain_async: got ctl %b redirect %b trap %b want %b 0 0", ctlVec, redirectValid, trapTaken, CTL_ALLFL); end
      repeat (2) @(negedge clock);
      executeValid = 0; imemReady = 1; reset = 1;
      #1;
      checks++; if (redirectValid !== 1'b1 || redirectAddress !== 32'h0) begin errors++;
         $display("FAIL rstdrain_boot: got %b/%h want 1/00000000", redirectValid, redirectAddress); end
      for (int c = 0; c < 6; c++) begin
         @(negedge clock); #1;
         if (trapTaken !== 1'b0) traps++;
      end
      checks++; if (traps != 0) begin errors++; $display("FAIL rstdrain_no_trap: got %0d trap cycles want 0", traps); end
   endtask

   initial begin
      clear_inputs();
      reset = 0;
      test_reset();
      test_forward_directed();
      test_load_use();
      test_branch_hold();
      test_random_run();
      test_interrupt();
      test_trap_hold();
      test_reset_in_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
